// File: rtl/uart_tx.sv
// uart_tx: optical-link UART serialiser (idle low, start high, 8 data LSB first, low stop bits).
// One-entry holding register lets frames run back to back with no idle gap.
module uart_tx #(
   parameter int CLKS_PER_BIT = 1000,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_serial,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int SW = $clog2(STOP_BITS + 1);
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] T_PRE  = TW'(CLKS_PER_BIT - 2);
   localparam logic [SW-1:0] S_LAST = SW'(STOP_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q;
   logic [TW-1:0] timer_q;
   logic [SW-1:0] stop_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic [7:0]    hold_q;
   logic          hold_vld_q;
   logic          en_q;
   logic          serial_q;
   logic          busy_q;
   logic          done_q;

   logic bit_end;
   logic stop_end;
   logic load;
   logic accept;

   // Shifter reload happens from IDLE or at the very end of the last stop period;
   // the hold slot frees on that same edge, so a new byte may be taken then.
   assign bit_end  = (timer_q == T_LAST);
   assign stop_end = (state_q == STOP) && bit_end && (stop_q == S_LAST);
   assign load     = hold_vld_q & ((state_q == IDLE) | stop_end);
   assign tx_ready = en_q & (~hold_vld_q | load);
   assign accept   = tx_valid & tx_ready;

   assign tx_serial = serial_q;
   assign tx_busy   = busy_q;
   assign tx_done   = done_q;

   // Holding register, frame FSM and registered line/status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         stop_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         en_q       <= 1'b0;
         serial_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         en_q   <= 1'b1;
         done_q <= 1'b0;
         if (accept) begin
            hold_q     <= tx_data;
            hold_vld_q <= 1'b1;
         end else if (load) begin
            hold_vld_q <= 1'b0;
         end
         unique case (state_q)
            IDLE: begin
               if (hold_vld_q) begin
                  state_q  <= START;
                  shift_q  <= hold_q;
                  timer_q  <= '0;
                  serial_q <= 1'b1;
                  busy_q   <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  state_q  <= DATA;
                  timer_q  <= '0;
                  bit_q    <= '0;
                  serial_q <= shift_q[0];
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  timer_q <= '0;
                  if (bit_q == 3'd7) begin
                     state_q  <= STOP;
                     stop_q   <= '0;
                     serial_q <= 1'b0;
                  end else begin
                     bit_q    <= bit_q + 3'd1;
                     shift_q  <= shift_q >> 1;
                     serial_q <= shift_q[1];
                  end
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            STOP: begin
               if (timer_q == T_PRE && stop_q == S_LAST) begin
                  done_q <= 1'b1;
               end
               if (bit_end) begin
                  timer_q <= '0;
                  if (stop_q != S_LAST) begin
                     stop_q <= stop_q + 1'b1;
                  end else if (hold_vld_q) begin
                     state_q  <= START;
                     shift_q  <= hold_q;
                     serial_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx.
// Three instances: 8 clk/bit x1 stop, 16 clk/bit x2 stop, 1000 clk/bit loopback.
module tb_uart_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] d;
   logic       va, vb, vl;
   logic       rd_a, ser_a, bz_a, dn_a;
   logic       rd_b, ser_b, bz_b, dn_b;
   logic       rd_l, ser_l, bz_l, dn_l;

   uart_tx #(.CLKS_PER_BIT(8), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst(rst), .tx_data(d), .tx_valid(va), .tx_ready(rd_a),
      .tx_serial(ser_a), .tx_busy(bz_a), .tx_done(dn_a));

   uart_tx #(.CLKS_PER_BIT(16), .STOP_BITS(2)) dut_b (
      .clk(clk), .rst(rst), .tx_data(d), .tx_valid(vb), .tx_ready(rd_b),
      .tx_serial(ser_b), .tx_busy(bz_b), .tx_done(dn_b));

   uart_tx #(.CLKS_PER_BIT(1000), .STOP_BITS(1)) dut_l (
      .clk(clk), .rst(rst), .tx_data(d), .tx_valid(vl), .tx_ready(rd_l),
      .tx_serial(ser_l), .tx_busy(bz_l), .tx_done(dn_l));

   int total = 0;
   int bad   = 0;
   int sel   = 0;
   logic ln, dn, bz, rd;

   always_comb begin
      ln = ser_a; dn = dn_a; bz = bz_a; rd = rd_a;
      case (sel)
         1: begin ln = ser_b; dn = dn_b; bz = bz_b; rd = rd_b; end
         2: begin ln = ser_l; dn = dn_l; bz = bz_l; rd = rd_l; end
         default: ;
      endcase
   end

   // expected line level at frame cycle k (k=1 is the first start-bit cycle)
   function automatic logic expb(input logic [7:0] b, input int k, input int cpb);
      if (k <= cpb) return 1'b1;
      if (k <= 9*cpb) return b[(k-cpb-1)/cpb];
      return 1'b0;
   endfunction

   // call just after the edge that begins the start bit
   task automatic chk_frame(input string nm, input logic [7:0] b, input int cpb,
                            input int ns, input bit hf, input bit more);
      int L;
      logic e;
      L = (9+ns)*cpb;
      for (int k = 1; k <= L; k++) begin
         @(negedge clk);
         e = expb(b, k, cpb);
         total++;
         if (ln !== e) begin
            bad++;
            $display("FAIL %s line k=%0d got=%b exp=%b", nm, k, ln, e);
         end
         total++;
         if (dn !== 1'(k == L)) begin
            bad++;
            $display("FAIL %s done k=%0d got=%b exp=%b", nm, k, dn, k == L);
         end
         total++;
         if (bz !== 1'b1) begin
            bad++;
            $display("FAIL %s busy k=%0d got=%b exp=1", nm, k, bz);
         end
         total++;
         if (rd !== 1'(!hf || k == L)) begin
            bad++;
            $display("FAIL %s ready k=%0d got=%b exp=%b", nm, k, rd, !hf || k == L);
         end
      end
      if (!more) begin
         @(negedge clk);
         total++;
         if ({bz, ln, dn, rd} !== 4'b0001) begin
            bad++;
            $display("FAIL %s after busy,line,done,ready got=%b exp=0001", nm, {bz, ln, dn, rd});
         end
      end
   endtask

   task automatic test_reset;
      sel = 0;
      rst = 1'b1; va = 1'b0; vb = 1'b0; vl = 1'b0; d = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({rd, ln, bz, dn} !== 4'b0000) begin
         bad++;
         $display("FAIL reset ready,line,busy,done got=%b exp=0000", {rd, ln, bz, dn});
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (rd !== 1'b0) begin
         bad++;
         $display("FAIL reset ready before first edge got=%b exp=0", rd);
      end
      @(posedge clk);
      #1;
      total++;
      if (rd !== 1'b1) begin
         bad++;
         $display("FAIL reset ready after first edge got=%b exp=1", rd);
      end
   endtask

   task automatic test_single;
      sel = 0;
      d = 8'hA5; va = 1'b1;
      @(posedge clk);
      #1 va = 1'b0;
      total++;
      if ({ln, bz} !== 2'b00) begin
         bad++;
         $display("FAIL single line,busy at accept got=%b exp=00", {ln, bz});
      end
      @(posedge clk);
      #1;
      chk_frame("single_A5", 8'hA5, 8, 1, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back;
      sel = 0;
      @(posedge clk);
      #1 d = 8'h00; va = 1'b1;
      @(posedge clk);
      #1 d = 8'hFF;
      @(posedge clk);
      #1 va = 1'b0;
      chk_frame("b2b_00", 8'h00, 8, 1, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      chk_frame("b2b_FF", 8'hFF, 8, 1, 1'b0, 1'b0);
   endtask

   task automatic test_backpressure;
      sel = 0;
      @(posedge clk);
      #1 d = 8'h11; va = 1'b1;
      @(posedge clk);
      #1 d = 8'h22;
      @(posedge clk);
      #1 d = 8'h33;
      chk_frame("bp_11", 8'h11, 8, 1, 1'b1, 1'b1);
      @(posedge clk);
      #1 va = 1'b0;
      chk_frame("bp_22", 8'h22, 8, 1, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      chk_frame("bp_33", 8'h33, 8, 1, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset;
      sel = 0;
      @(posedge clk);
      #1 d = 8'h5A; va = 1'b1;
      @(posedge clk);
      #1 va = 1'b0;
      @(posedge clk);
      #1;
      repeat (43) @(negedge clk);
      total++;
      if (ln !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid line bit4 got=%b exp=1", ln);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({ln, bz, rd, dn} !== 4'b0000) begin
         bad++;
         $display("FAIL rst_mid line,busy,ready,done got=%b exp=0000", {ln, bz, rd, dn});
      end
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      total++;
      if ({ln, rd} !== 2'b00) begin
         bad++;
         $display("FAIL rst_mid line,ready held got=%b exp=00", {ln, rd});
      end
      @(posedge clk);
      #1;
      total++;
      if ({rd, ln, bz} !== 3'b100) begin
         bad++;
         $display("FAIL rst_mid release ready,line,busy got=%b exp=100", {rd, ln, bz});
      end
      d = 8'hC3; va = 1'b1;
      @(posedge clk);
      #1 va = 1'b0;
      @(posedge clk);
      #1;
      chk_frame("rst_C3", 8'hC3, 8, 1, 1'b0, 1'b0);
   endtask

   task automatic test_two_stop;
      sel = 1;
      @(posedge clk);
      #1 d = 8'h80; vb = 1'b1;
      @(posedge clk);
      #1 vb = 1'b0;
      @(posedge clk);
      #1;
      chk_frame("stop2_80", 8'h80, 16, 2, 1'b0, 1'b0);
   endtask

   task automatic rx_byte(input int cpb, output logic [7:0] b, output bit ok);
      ok = 1'b0;
      b  = 8'h00;
      for (int t = 0; t < 20*cpb; t++) begin
         @(negedge clk);
         if (ln) break;
      end
      if (!ln) return;
      repeat (cpb/2 - 1) @(negedge clk);
      if (!ln) return;
      for (int i = 0; i < 8; i++) begin
         repeat (cpb) @(negedge clk);
         b[i] = ln;
      end
      repeat (cpb) @(negedge clk);
      if (ln) return;
      ok = 1'b1;
   endtask

   task automatic test_loopback;
      logic [7:0] tx_q [5];
      sel = 2;
      tx_q = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'h3C};
      @(posedge clk);
      #1;
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               d = tx_q[i];
               vl = 1'b1;
               for (int t = 0; t < 30000; t++) begin
                  @(negedge clk);
                  if (rd) break;
               end
               total++;
               if (!rd) begin
                  bad++;
                  $display("FAIL loop accept timeout byte=%0d got=0 exp=1", i);
               end
               @(posedge clk);
               #1 vl = 1'b0;
            end
         end
         begin
            logic [7:0] got;
            bit ok;
            for (int i = 0; i < 5; i++) begin
               rx_byte(1000, got, ok);
               total++;
               if (!ok || got !== tx_q[i]) begin
                  bad++;
                  $display("FAIL loop rx byte=%0d got=%h ok=%0d exp=%h", i, got, ok, tx_q[i]);
               end
            end
         end
      join
      repeat (1500) @(negedge clk);
      total++;
      if ({ln, bz} !== 2'b00) begin
         bad++;
         $display("FAIL loop idle line,busy got=%b exp=00", {ln, bz});
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_async_reset();
      test_two_stop();
      test_loopback();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
